gray_chunk_scheduler: RTL

- Frame-level sequencer for the grayscale engine.
- Splits a frame into NUM_CHUNKS chunks and starts the engine once per chunk with a single-cycle pulse.
- Consumes the engine's valid/bw stream and counts white pixels per frame.
- Shares the SDRAM read port between the engine and the display reader. The display wins between chunks; a started chunk is never preempted.

---
 rtl/gray_chunk_scheduler.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/gray_chunk_scheduler.sv
// Frame sequencer for the grayscale engine. It starts one engine pass per chunk, counts the white
// pixels in each frame, and lets the display reader take the SDRAM read port between chunks.
module gray_chunk_scheduler #(
    parameter int NUM_CHUNKS   = 16,
    parameter int CHUNK_PIXELS = 169,
    parameter int TIMEOUT      = 64,
    parameter int WHITE_LEVEL  = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_frame_start,
    input  logic        i_disp_req,
    output logic        o_disp_gnt,
    output logic        o_gs_start,
    input  logic        i_gs_valid,
    input  logic [9:0]  i_gs_bw,
    output logic [9:0]  o_chunk_idx,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic [19:0] o_white_count,
    output logic        o_error
);
    localparam int TW = $clog2(TIMEOUT + 1);
    // One spare count above CHUNK_PIXELS, so a long chunk saturates instead of wrapping back to a match.
    localparam int BW = $clog2(CHUNK_PIXELS + 2);
    localparam logic [TW-1:0] TO_LIM   = TW'(TIMEOUT - 1);
    localparam logic [BW-1:0] FULL     = BW'(CHUNK_PIXELS);
    localparam logic [9:0]    LAST_IDX = 10'(NUM_CHUNKS - 1);
    localparam logic [9:0]    WHITE    = 10'(WHITE_LEVEL);

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_START, S_WAIT_V, S_STREAM, S_NEXT, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [9:0]    idx_q, idx_d;
    logic [19:0]   acc_q, acc_d;
    logic [19:0]   white_q, white_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [TW-1:0] to_q, to_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic          gnt_q, gnt_d;
    logic          count_beat;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            white_q <= '0;
            beat_q  <= '0;
            to_q    <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            gnt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            white_q <= white_d;
            beat_q  <= beat_d;
            to_q    <= to_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            gnt_q   <= gnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        white_d    = white_q;
        beat_d     = beat_q;
        to_d       = to_q;
        busy_d     = busy_q;
        err_d      = err_q;
        count_beat = 1'b0;
        // The grant only follows the request while no chunk is running, so a chunk that has started always finishes.
        gnt_d      = i_disp_req && (state_q == S_IDLE || state_q == S_ARB);

        case (state_q)
            S_IDLE: begin
                if (i_frame_start) begin
                    state_d = S_ARB;
                    idx_d   = '0;
                    acc_d   = '0;
                    beat_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            S_ARB: begin
                if (!i_disp_req) state_d = S_START;
            end
            S_START: begin
                to_d    = '0;
                state_d = S_WAIT_V;
            end
            S_WAIT_V: begin
                if (i_gs_valid) begin
                    count_beat = 1'b1;
                    state_d    = S_STREAM;
                end else if (to_q + TW'(1) == TO_LIM) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            S_STREAM: begin
                if (i_gs_valid) begin
                    count_beat = 1'b1;
                end else begin
                    if (beat_q != FULL) err_d = 1'b1;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 10'd1;
                    beat_d  = '0;
                    state_d = S_ARB;
                end
            end
            S_DONE: begin
                white_d = acc_q;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (count_beat) begin
            if (beat_q != '1) beat_d = beat_q + BW'(1);
            if (i_gs_bw == WHITE && acc_q != '1) acc_d = acc_q + 20'd1;
        end
    end

    assign o_disp_gnt    = gnt_q;
    assign o_gs_start    = (state_q == S_START);
    assign o_frame_done  = (state_q == S_DONE);
    assign o_chunk_idx   = idx_q;
    assign o_busy        = busy_q;
    assign o_white_count = white_q;
    assign o_error       = err_q;
endmodule
